// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fb_pkg
//  Purpose  : Shared types, frame size defaults and palette lookup for the
//             framebuffer writer.
//  Revision : 1.0  initial release
// ============================================================================
package fb_pkg;

    typedef enum logic [1:0] {
        STREAM    = 2'd0,
        BLANK     = 2'd1,
        SWAP_WAIT = 2'd2
    } fw_state_t;

    localparam int FB_W_DEFAULT = 160;
    localparam int FB_H_DEFAULT = 120;

    // Index i selects palette[2i+1:2i].
    function automatic logic [1:0] pal_map(input logic [7:0] palette, input logic [1:0] idx);
        return palette[{idx, 1'b0} +: 2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/fb_frame_writer_if.sv
`default_nettype none
// ============================================================================
//  Module   : fb_frame_writer_if
//  Purpose  : PPU pixel stream, control inputs and framebuffer write/swap bus.
//  Revision : 1.0  initial release
// ============================================================================
interface fb_frame_writer_if;

    logic       pix_valid;
    logic       pix_ready;
    logic [1:0] pix_color;
    logic       pix_sof;
    logic [7:0] palette;
    logic       lcd_on;
    logic [7:0] fb_x;
    logic [7:0] fb_y;
    logic [1:0] fb_color;
    logic       fb_wr_en;
    logic       swap_req;
    logic       swap_ack;
    logic       frame_done;
    logic       frame_err;

    // The frame writer masters the framebuffer writes and swap requests.
    modport master (
        input  pix_valid, pix_color, pix_sof, palette, lcd_on, swap_ack,
        output pix_ready, fb_x, fb_y, fb_color, fb_wr_en, swap_req, frame_done, frame_err
    );

    modport slave (
        output pix_valid, pix_color, pix_sof, palette, lcd_on, swap_ack,
        input  pix_ready, fb_x, fb_y, fb_color, fb_wr_en, swap_req, frame_done, frame_err
    );

endinterface
`default_nettype wire

// File: rtl/fb_raster_counter.sv
`default_nettype none
// ============================================================================
//  Module   : fb_raster_counter
//  Purpose  : Raster-order x/y position counter with clear, advance and an
//             optional restart from the origin; flags the last pixel.
//  Revision : 1.0  initial release
// ============================================================================
module fb_raster_counter #(
    parameter int FB_W = 160,
    parameter int FB_H = 120,
    parameter int XW   = 8,
    parameter int YW   = 7
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          i_clear,
    input  wire logic          i_advance,
    input  wire logic          i_from_origin,
    output logic [XW-1:0]      o_x,
    output logic [YW-1:0]      o_y,
    output logic               o_at_origin,
    output logic               o_last
);

    localparam logic [XW-1:0] c_X_MAX = XW'(FB_W - 1);
    localparam logic [YW-1:0] c_Y_MAX = YW'(FB_H - 1);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [XW-1:0] w_base_x;
    logic [YW-1:0] w_base_y;
    logic          w_x_end;
    logic          w_y_end;

    // The position used for this cycle's write; a restart writes at the origin.
    assign w_base_x    = i_from_origin ? '0 : r_x;
    assign w_base_y    = i_from_origin ? '0 : r_y;
    assign w_x_end     = (w_base_x == c_X_MAX);
    assign w_y_end     = (w_base_y == c_Y_MAX);
    assign o_x         = w_base_x;
    assign o_y         = w_base_y;
    assign o_at_origin = (r_x == '0) && (r_y == '0);
    assign o_last      = w_x_end && w_y_end;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_advance) begin
            if (w_x_end) begin
                r_x <= '0;
                r_y <= w_y_end ? '0 : w_base_y + YW'(1);
            end else begin
                r_x <= w_base_x + XW'(1);
                r_y <= w_base_y;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fb_frame_writer.sv
`default_nettype none
// ============================================================================
//  Module   : fb_frame_writer
//  Purpose  : Turns the PPU raster pixel stream into addressed framebuffer
//             writes, blanks the screen while the LCD is off, and handshakes
//             buffer swaps at end of frame.
//  Revision : 1.0  initial release
// ============================================================================
module fb_frame_writer
    import fb_pkg::*;
#(
    parameter int FB_W = FB_W_DEFAULT,
    parameter int FB_H = FB_H_DEFAULT
) (
    input  wire logic           clk,
    input  wire logic           reset,
    fb_frame_writer_if.master   bus
);

    localparam int XW = (FB_W > 1) ? $clog2(FB_W) : 1;
    localparam int YW = (FB_H > 1) ? $clog2(FB_H) : 1;

    localparam logic [1:0] c_ST_STREAM    = STREAM;
    localparam logic [1:0] c_ST_BLANK     = BLANK;
    localparam logic [1:0] c_ST_SWAP_WAIT = SWAP_WAIT;

    logic [1:0]    r_state;
    logic [7:0]    r_fb_x;
    logic [7:0]    r_fb_y;
    logic [1:0]    r_fb_color;
    logic          r_fb_wr_en;
    logic          r_swap_req;
    logic          r_frame_done;
    logic          r_frame_err;

    logic          w_ready;
    logic          w_transfer;
    logic          w_resync;
    logic          w_blank_wr;
    logic          w_advance;
    logic          w_clear;
    logic          w_at_origin;
    logic          w_last;
    logic [XW-1:0] w_x;
    logic [YW-1:0] w_y;

    assign w_ready    = !reset && (r_state == c_ST_STREAM) && bus.lcd_on;
    assign w_transfer = bus.pix_valid && w_ready;
    // A start-of-frame marker anywhere but the origin resynchronises to (0,0).
    assign w_resync   = w_transfer && bus.pix_sof && !w_at_origin;
    assign w_blank_wr = (r_state == c_ST_BLANK);
    assign w_advance  = w_transfer || w_blank_wr;
    assign w_clear    = (r_state == c_ST_STREAM) && !bus.lcd_on;

    fb_raster_counter #(
        .FB_W (FB_W),
        .FB_H (FB_H),
        .XW   (XW),
        .YW   (YW)
    ) u_raster (
        .clk           (clk),
        .reset         (reset),
        .i_clear       (w_clear),
        .i_advance     (w_advance),
        .i_from_origin (w_resync),
        .o_x           (w_x),
        .o_y           (w_y),
        .o_at_origin   (w_at_origin),
        .o_last        (w_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_STREAM;
            r_fb_x       <= '0;
            r_fb_y       <= '0;
            r_fb_color   <= '0;
            r_fb_wr_en   <= 1'b0;
            r_swap_req   <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_fb_wr_en   <= w_advance;
            r_frame_err  <= w_resync;
            r_frame_done <= 1'b0;
            if (w_advance) begin
                r_fb_x     <= 8'(w_x);
                r_fb_y     <= 8'(w_y);
                r_fb_color <= w_blank_wr ? 2'b00 : pal_map(bus.palette, bus.pix_color);
            end
            case (r_state)
                c_ST_STREAM: begin
                    if (!bus.lcd_on) begin
                        r_state <= c_ST_BLANK;
                    end else if (w_transfer && w_last) begin
                        r_swap_req <= 1'b1;
                        r_state    <= c_ST_SWAP_WAIT;
                    end
                end
                c_ST_BLANK: begin
                    if (w_last) begin
                        r_swap_req <= 1'b1;
                        r_state    <= c_ST_SWAP_WAIT;
                    end
                end
                c_ST_SWAP_WAIT: begin
                    // Dropping the request on the ack edge yields exactly one swap.
                    if (bus.swap_ack) begin
                        r_swap_req   <= 1'b0;
                        r_frame_done <= 1'b1;
                        r_state      <= bus.lcd_on ? c_ST_STREAM : c_ST_BLANK;
                    end
                end
                default: r_state <= c_ST_STREAM;
            endcase
        end
    end

    assign bus.pix_ready  = w_ready;
    assign bus.fb_x       = r_fb_x;
    assign bus.fb_y       = r_fb_y;
    assign bus.fb_color   = r_fb_color;
    assign bus.fb_wr_en   = r_fb_wr_en;
    assign bus.swap_req   = r_swap_req;
    assign bus.frame_done = r_frame_done;
    assign bus.frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_fb_frame_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fb_frame_writer
//  Purpose  : Scoreboard bench for fb_frame_writer: streaming, palette,
//             resync, blanking, swap handshake, backpressure and reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fb_frame_writer;

    localparam int W    = 160;
    localparam int H    = 120;
    localparam int NPIX = W * H;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fb_frame_writer_if bus();

    fb_frame_writer #(.FB_W(W), .FB_H(H)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          err_cnt  = 0;
    int          done_cnt = 0;
    int          mx = 0;
    int          my = 0;
    logic [17:0] exp_q[$];
    logic [17:0] mon_e;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] shade_of(input logic [7:0] pal, input logic [1:0] c);
        logic [7:0] s;
        s = pal >> (2 * int'(c));
        return s[1:0];
    endfunction

    // Writes leave the DUT in order; each is matched to the oldest expectation.
    always @(negedge clk) begin
        if (bus.fb_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("wr_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("wr", 32'({bus.fb_x, bus.fb_y, bus.fb_color}), 32'(mon_e));
            end
        end
        if (bus.frame_err === 1'b1)  err_cnt++;
        if (bus.frame_done === 1'b1) done_cnt++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            #1;
        end
    endtask

    task automatic send_pixel(input logic [1:0] c, input logic sof);
        int wx;
        int wy;
        bus.pix_valid = 1'b1;
        bus.pix_color = c;
        bus.pix_sof   = sof;
        #1;
        check_eq("pix_ready", 32'(bus.pix_ready), 32'd1);
        if (sof && (mx != 0 || my != 0)) begin
            wx = 0;
            wy = 0;
        end else begin
            wx = mx;
            wy = my;
        end
        exp_q.push_back({8'(wx), 8'(wy), shade_of(bus.palette, c)});
        mx = wx + 1;
        my = wy;
        if (mx == W) begin
            mx = 0;
            my = (wy + 1 == H) ? 0 : wy + 1;
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
    endtask

    task automatic push_blank();
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++)
                exp_q.push_back({8'(xx), 8'(yy), 2'b00});
        mx = 0;
        my = 0;
    endtask

    task automatic wait_swap(input int budget);
        int n;
        n = 0;
        while (bus.swap_req !== 1'b1 && n < budget) begin
            step(1);
            n++;
        end
        check_eq("swap_req_set", 32'(bus.swap_req), 32'd1);
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic ack_swap(input logic exp_ready);
        bus.swap_ack = 1'b1;
        step(1);
        bus.swap_ack = 1'b0;
        check_eq("swap_req_clr", 32'(bus.swap_req), 32'd0);
        check_eq("done_pulse", 32'(bus.frame_done), 32'd1);
        check_eq("ready_after_ack", 32'(bus.pix_ready), 32'(exp_ready));
    endtask

    initial begin
        reset         = 1'b1;
        bus.pix_valid = 1'b0;
        bus.pix_color = 2'd0;
        bus.pix_sof   = 1'b0;
        bus.palette   = 8'hE4;
        bus.lcd_on    = 1'b1;
        bus.swap_ack  = 1'b0;
        step(3);
        check_eq("reset_outputs", 32'({bus.fb_x, bus.fb_y, bus.fb_color, bus.fb_wr_en,
                                       bus.swap_req, bus.frame_done, bus.frame_err}), 32'd0);
        check_eq("reset_ready", 32'(bus.pix_ready), 32'd0);
        reset = 1'b0;
        #1;
        check_eq("ready_idle", 32'(bus.pix_ready), 32'd1);

        // Full frame, identity palette, colours cycling 0..3.
        for (int k = 0; k < NPIX; k++) send_pixel(2'(k % 4), k == 0);
        check_eq("last_write", 32'({bus.fb_x, bus.fb_y, bus.fb_color}), 32'({8'd159, 8'd119, 2'd3}));
        check_eq("swap_rise", 32'(bus.swap_req), 32'd1);
        check_eq("ready_swap_wait", 32'(bus.pix_ready), 32'd0);
        step(50);
        check_eq("swap_hold", 32'(bus.swap_req), 32'd1);
        check_eq("no_writes_in_wait", 32'(exp_q.size()), 32'd0);
        ack_swap(1'b1);
        step(1);
        check_eq("done_single", 32'(bus.frame_done), 32'd0);
        check_eq("done_count_a", 32'(done_cnt), 32'd1);

        // Palette 1B: colour 1 maps to shade 2'b10; start-less origin pixel.
        bus.palette = 8'h1B;
        send_pixel(2'd1, 1'b0);
        check_eq("pal_1b_color", 32'(bus.fb_color), 32'd2);
        check_eq("pal_1b_wr", 32'(bus.fb_wr_en), 32'd1);

        // Advance to (37,5) under random 30% valid duty, then resync mid-frame.
        for (int sent = 1; sent < 5 * W + 37; ) begin
            if ($urandom_range(0, 99) < 30) begin
                send_pixel(2'($urandom_range(0, 3)), 1'b0);
                sent++;
            end else begin
                step(1);
            end
        end
        send_pixel(2'($urandom_range(0, 3)), 1'b1);
        check_eq("sof_err", 32'(bus.frame_err), 32'd1);
        check_eq("sof_at_origin", 32'({bus.fb_x, bus.fb_y}), 32'd0);
        send_pixel(2'($urandom_range(0, 3)), 1'b0);
        check_eq("after_sof_pos", 32'({bus.fb_x, bus.fb_y}), 32'({8'd1, 8'd0}));
        check_eq("err_single", 32'(bus.frame_err), 32'd0);
        for (int k = 0; k < NPIX - 2; k++) send_pixel(2'($urandom_range(0, 3)), 1'b0);
        check_eq("swap_after_resync", 32'(bus.swap_req), 32'd1);
        ack_swap(1'b1);
        check_eq("err_count", 32'(err_cnt), 32'd1);

        // LCD off at (80,60): immediate stall, then blank fill.
        for (int k = 0; k < 60 * W + 80; k++) send_pixel(2'($urandom_range(0, 3)), 1'b0);
        bus.lcd_on    = 1'b0;
        bus.pix_valid = 1'b1;
        #1;
        check_eq("ready_lcd_off", 32'(bus.pix_ready), 32'd0);
        bus.pix_valid = 1'b0;
        push_blank();
        wait_swap(NPIX + 50);
        ack_swap(1'b0);
        push_blank();
        step(1);
        check_eq("done_single_b", 32'(bus.frame_done), 32'd0);
        step(5000);
        bus.lcd_on = 1'b1;
        #1;
        check_eq("ready_mid_blank", 32'(bus.pix_ready), 32'd0);
        wait_swap(NPIX);

        // Reset while waiting for the swap acknowledge.
        reset = 1'b1;
        step(1);
        check_eq("rst_wait_outputs", 32'({bus.fb_x, bus.fb_y, bus.fb_color, bus.fb_wr_en,
                                          bus.swap_req, bus.frame_done, bus.frame_err}), 32'd0);
        check_eq("rst_wait_ready", 32'(bus.pix_ready), 32'd0);
        step(1);
        reset = 1'b0;
        mx = 0;
        my = 0;
        send_pixel(2'd3, 1'b0);
        check_eq("post_rst_pos", 32'({bus.fb_x, bus.fb_y, bus.fb_wr_en}), 32'({8'd0, 8'd0, 1'b1}));
        step(3);
        check_eq("no_spurious_done", 32'(done_cnt), 32'd3);
        check_eq("final_queue", 32'(exp_q.size()), 32'd0);
        check_eq("final_err", 32'(err_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
